// File: rtl/pipe_pkg.sv
// pipe_pkg
// Shared definitions for the fetch stage and its IF/ID consumer.
//   XLEN         data and PC width in bits
//   RESET_PC     byte PC fetched first after reset
//   INSTR_BYTES  byte stride between sequential instructions
//   fetchEntry_t one fetch queue entry, {instr, pcplus}; the queue storage
//                packs its entries in this same bit order

package pipe_pkg;

  localparam int XLEN = 32;

  localparam logic [XLEN-1:0] RESET_PC = '0;

  localparam int INSTR_BYTES = 4;

  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pcplus;
  } fetchEntry_t;

endpackage

// File: rtl/fq_ram.sv
// fq_ram
// Register-array storage for the fetch queue: DEPTH entries of WIDTH bits,
// one synchronous write port and one asynchronous read port at the head.
// Ports:
//   clk     clock
//   wrEn    write the entry at wrAddr this cycle
//   wrAddr  write index (queue tail)
//   wrData  entry to write
//   rdAddr  read index (queue head)
//   rdData  entry at rdAddr, combinational from the stored registers

module fq_ram #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     wrEn,
  input  logic [$clog2(DEPTH)-1:0] wrAddr,
  input  logic [WIDTH-1:0]         wrData,
  input  logic [$clog2(DEPTH)-1:0] rdAddr,
  output logic [WIDTH-1:0]         rdData
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Storage needs no reset: an entry is only ever read once the queue
  // pointers say it has been written since the last reset or flush.
  always_ff @(posedge clk) begin
    if (wrEn) begin
      mem[wrAddr] <= wrData;
    end
  end

  // The head entry comes straight from the registers, so decode never sees
  // a combinational path from the instruction memory.
  assign rdData = mem[rdAddr];

endmodule

// File: rtl/fetch_queue.sv
// fetch_queue
// Instruction fetch queue between instruction memory and decode. Issues one
// word fetch per cycle while the queue has credit, captures each response the
// cycle after its request, and presents entries to decode in program order.
// Ports:
//   clk             clock, all state updates on the rising edge
//   rst             asynchronous active-low reset
//   redirect_valid  redirect from ID; flushes the queue and restarts fetch
//   redirect_pc     byte target of the redirect
//   imem_req        fetch request issued this cycle
//   imem_addr       word address of the request (fetch PC >> 2)
//   imem_rdata      instruction word, valid the cycle after imem_req
//   deq_ready       decode accepts the head entry
//   deq_valid       head entry available
//   deq_instr       head instruction
//   deq_pcplus      head PC + 4
//   occupancy       number of valid entries held

module fetch_queue #(
  parameter int              XLEN     = pipe_pkg::XLEN,
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = pipe_pkg::RESET_PC
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     redirect_valid,
  input  logic [XLEN-1:0]          redirect_pc,
  output logic                     imem_req,
  output logic [XLEN-1:0]          imem_addr,
  input  logic [XLEN-1:0]          imem_rdata,
  input  logic                     deq_ready,
  output logic                     deq_valid,
  output logic [XLEN-1:0]          deq_instr,
  output logic [XLEN-1:0]          deq_pcplus,
  output logic [$clog2(DEPTH):0]   occupancy
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int OCC_W = PTR_W + 1;

  localparam logic [OCC_W:0]   DEPTH_CREDIT = (OCC_W + 1)'(DEPTH);
  localparam logic [XLEN-1:0]  PC_STEP      = XLEN'(pipe_pkg::INSTR_BYTES);

  logic [XLEN-1:0]   fetchPc;
  logic [XLEN-1:0]   reqPc;
  logic              inflight;
  logic              reqEpoch;
  logic              epoch;

  logic [PTR_W-1:0]  headPtr;
  logic [PTR_W-1:0]  tailPtr;
  logic [OCC_W-1:0]  occCount;

  logic [OCC_W:0]    creditUsed;
  logic              issueReq;
  logic              doEnq;
  logic              doDeq;

  logic [2*XLEN-1:0] wrData;
  logic [2*XLEN-1:0] headData;

  // A request is only issued if the queue can hold it together with the one
  // still in flight, so the queue can never overflow. Counting entries before
  // this cycle's dequeue is conservative but keeps the credit purely
  // registered. Requests are held off during reset and in a redirect cycle.
  assign creditUsed = {1'b0, occCount} + {{OCC_W{1'b0}}, inflight};
  assign issueReq   = rst && !redirect_valid && (creditUsed < DEPTH_CREDIT);

  // The response is captured at the end of the cycle after its request. A
  // redirect in that same cycle, or a response from an older epoch, is
  // dropped so the wrong-path word never reaches the queue.
  assign doEnq = inflight && (reqEpoch == epoch) && !redirect_valid;

  // deq_valid already excludes the empty and redirect cases, so deq_ready is
  // ignored whenever there is nothing legal to hand over.
  assign deq_valid = (occCount != '0) && !redirect_valid;
  assign doDeq     = deq_valid && deq_ready;

  assign wrData = {imem_rdata, reqPc + PC_STEP};

  assign imem_req  = issueReq;
  assign imem_addr = fetchPc >> 2;
  assign occupancy = occCount;

  assign deq_instr  = headData[2*XLEN-1:XLEN];
  assign deq_pcplus = headData[XLEN-1:0];

  // Fetch side: the fetch PC advances by one instruction per issued request,
  // and the PC and epoch of that request are held alongside the in-flight
  // flag so the response can be tagged a cycle later. A redirect restarts
  // fetch at the target and flips the epoch so anything already requested is
  // treated as stale.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetchPc  <= RESET_PC;
      reqPc    <= '0;
      inflight <= 1'b0;
      reqEpoch <= 1'b0;
      epoch    <= 1'b0;
    end else if (redirect_valid) begin
      fetchPc  <= redirect_pc;
      inflight <= 1'b0;
      epoch    <= ~epoch;
    end else begin
      inflight <= issueReq;
      if (issueReq) begin
        fetchPc  <= fetchPc + PC_STEP;
        reqPc    <= fetchPc;
        reqEpoch <= epoch;
      end
    end
  end

  // Queue bookkeeping: pointers wrap naturally because DEPTH is a power of
  // two. A simultaneous enqueue and dequeue leaves the count unchanged. A
  // redirect empties the queue in one cycle by resetting the pointers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      headPtr  <= '0;
      tailPtr  <= '0;
      occCount <= '0;
    end else if (redirect_valid) begin
      headPtr  <= '0;
      tailPtr  <= '0;
      occCount <= '0;
    end else begin
      if (doEnq) begin
        tailPtr <= tailPtr + PTR_W'(1);
      end
      if (doDeq) begin
        headPtr <= headPtr + PTR_W'(1);
      end
      case ({doEnq, doDeq})
        2'b10:   occCount <= occCount + OCC_W'(1);
        2'b01:   occCount <= occCount - OCC_W'(1);
        default: occCount <= occCount;
      endcase
    end
  end

  fq_ram #(
    .WIDTH (2 * XLEN),
    .DEPTH (DEPTH)
  ) u_ram (
    .clk    (clk),
    .wrEn   (doEnq),
    .wrAddr (tailPtr),
    .wrData (wrData),
    .rdAddr (headPtr),
    .rdData (headData)
  );

endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue
// Drives two fetch queues (DEPTH 4 and DEPTH 8) with identical control
// stimulus; each has its own instruction memory returning addr*4. A
// reference model per queue tracks the ordered stream of fetched PCs and
// checks occupancy, handshakes, request addresses and dequeued entries.

module tb_fetch_queue;

  localparam int          NUM_DUT  = 2;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  typedef struct {
    logic [31:0] pc;
    int          pushCyc;
  } expEntry_t;

  logic clk = 1'b0;
  logic rst;
  logic redirectValid;
  logic [31:0] redirectPc;
  logic deqReady;

  logic [NUM_DUT-1:0]       imemReq;
  logic [NUM_DUT-1:0]       deqValid;
  logic [NUM_DUT-1:0][31:0] imemAddr;
  logic [NUM_DUT-1:0][31:0] imemRdata;
  logic [NUM_DUT-1:0][31:0] deqInstr;
  logic [NUM_DUT-1:0][31:0] deqPcplus;
  logic [NUM_DUT-1:0][3:0]  occ;

  int nChecks = 0;
  int nFails  = 0;
  int cyc     = 0;

  expEntry_t   expQ    [NUM_DUT][$];
  logic [31:0] modelPc [NUM_DUT];

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < NUM_DUT; g++) begin : gDut
    localparam int D = (g == 0) ? 4 : 8;
    logic [$clog2(D):0] occLocal;

    fetch_queue #(
      .XLEN     (32),
      .DEPTH    (D),
      .RESET_PC (RESET_PC)
    ) dut (
      .clk            (clk),
      .rst            (rst),
      .redirect_valid (redirectValid),
      .redirect_pc    (redirectPc),
      .imem_req       (imemReq[g]),
      .imem_addr      (imemAddr[g]),
      .imem_rdata     (imemRdata[g]),
      .deq_ready      (deqReady),
      .deq_valid      (deqValid[g]),
      .deq_instr      (deqInstr[g]),
      .deq_pcplus     (deqPcplus[g]),
      .occupancy      (occLocal)
    );

    assign occ[g] = 4'(occLocal);
  end

  function automatic int depthOf(input int k);
    return (k == 0) ? 4 : 8;
  endfunction

  function automatic logic [31:0] memWord(input logic [31:0] wordAddr);
    return wordAddr << 2;
  endfunction

  // Instruction memory: the word is valid only in the cycle after a request
  // and is junk otherwise.
  always @(posedge clk) begin
    for (int k = 0; k < NUM_DUT; k++) begin
      imemRdata[k] <= imemReq[k] ? memWord(imemAddr[k]) : 32'hDEAD_BEEF;
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    nChecks++;
    if (actual !== expected) begin
      nFails++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  // Reference model step for one queue. The expected queue holds every PC
  // the model decides to fetch, tagged with its fetch cycle; an entry is
  // visible to decode two cycles after its fetch. Requests are allowed while
  // fetched-but-not-dequeued entries stay below the depth.
  task automatic modelCycle(input int k);
    int        arrived;
    logic      expReq;
    logic      expValid;
    expEntry_t e;
    string     tag;
    tag = $sformatf("dut%0d", k);
    if (rst !== 1'b1) begin
      checkOutput({tag, ".rst_deq_valid"}, 32'(deqValid[k]), 32'd0);
      checkOutput({tag, ".rst_imem_req"},  32'(imemReq[k]),  32'd0);
      checkOutput({tag, ".rst_occupancy"}, 32'(occ[k]),      32'd0);
      expQ[k].delete();
      modelPc[k] = RESET_PC;
      return;
    end
    arrived = 0;
    for (int i = 0; i < expQ[k].size(); i++) begin
      if (expQ[k][i].pushCyc <= cyc - 2) arrived++;
    end
    expValid = (arrived != 0) && !redirectValid;
    expReq   = !redirectValid && (expQ[k].size() < depthOf(k));
    checkOutput({tag, ".occupancy"}, 32'(occ[k]),      32'(arrived));
    checkOutput({tag, ".deq_valid"}, 32'(deqValid[k]), 32'(expValid));
    checkOutput({tag, ".imem_req"},  32'(imemReq[k]),  32'(expReq));
    if (deqValid[k] && deqReady) begin
      if (expQ[k].size() == 0) begin
        nChecks++;
        nFails++;
        $display("[TB] FAIL %s.deq_extra: got instr 0x%08h, expected no entry", tag, deqInstr[k]);
      end else begin
        e = expQ[k].pop_front();
        checkOutput({tag, ".deq_instr"},  deqInstr[k],  memWord(e.pc >> 2));
        checkOutput({tag, ".deq_pcplus"}, deqPcplus[k], e.pc + 32'd4);
      end
    end
    if (redirectValid) begin
      expQ[k].delete();
      modelPc[k] = redirectPc;
    end else if (expReq) begin
      checkOutput({tag, ".imem_addr"}, imemAddr[k], modelPc[k] >> 2);
      e.pc      = modelPc[k];
      e.pushCyc = cyc;
      expQ[k].push_back(e);
      modelPc[k] = modelPc[k] + 32'd4;
    end
  endtask

  // Monitor: every cycle, away from the rising edge, compare both queues
  // against their models.
  always @(negedge clk) begin
    for (int k = 0; k < NUM_DUT; k++) begin
      modelCycle(k);
    end
  end

  task automatic applyStimulus(input logic r, input logic rv,
                               input logic [31:0] pc, input logic rdy);
    @(posedge clk);
    #1;
    rst           = r;
    redirectValid = rv;
    redirectPc    = pc;
    deqReady      = rdy;
  endtask

  initial begin
    logic found;
    rst           = 1'b0;
    redirectValid = 1'b0;
    redirectPc    = 32'd0;
    deqReady      = 1'b0;

    repeat (3) applyStimulus(1'b0, 1'b0, 32'd0, 1'b0);

    applyStimulus(1'b1, 1'b0, 32'd0, 1'b1);
    @(negedge clk);
    checkOutput("release_imem_req",  32'(imemReq[0]), 32'd1);
    checkOutput("release_imem_addr", imemAddr[0],     RESET_PC >> 2);
    applyStimulus(1'b1, 1'b0, 32'd0, 1'b1);
    @(negedge clk);
    checkOutput("cycle1_deq_valid", 32'(deqValid[0]), 32'd0);
    applyStimulus(1'b1, 1'b0, 32'd0, 1'b1);
    @(negedge clk);
    checkOutput("cycle2_deq_valid",  32'(deqValid[0]), 32'd1);
    checkOutput("cycle2_deq_instr",  deqInstr[0],      32'd0);
    checkOutput("cycle2_deq_pcplus", deqPcplus[0],     32'd4);
    applyStimulus(1'b1, 1'b0, 32'd0, 1'b1);
    @(negedge clk);
    checkOutput("cycle3_deq_instr",  deqInstr[0],  32'd4);
    checkOutput("cycle3_deq_pcplus", deqPcplus[0], 32'd8);
    repeat (8) applyStimulus(1'b1, 1'b0, 32'd0, 1'b1);

    repeat (10) applyStimulus(1'b1, 1'b0, 32'd0, 1'b0);
    @(negedge clk);
    checkOutput("full_occupancy", 32'(occ[0]),     32'd4);
    checkOutput("full_imem_req",  32'(imemReq[0]), 32'd0);

    applyStimulus(1'b1, 1'b0, 32'd0, 1'b1);
    applyStimulus(1'b1, 1'b0, 32'd0, 1'b0);
    applyStimulus(1'b1, 1'b1, 32'h100, 1'b0);
    @(negedge clk);
    checkOutput("redir_pre_occupancy", 32'(occ[0]), 32'd3);
    applyStimulus(1'b1, 1'b0, 32'd0, 1'b1);
    @(negedge clk);
    checkOutput("redir_r1_occupancy", 32'(occ[0]),     32'd0);
    checkOutput("redir_r1_imem_req",  32'(imemReq[0]), 32'd1);
    checkOutput("redir_r1_imem_addr", imemAddr[0],     32'h40);
    applyStimulus(1'b1, 1'b0, 32'd0, 1'b1);
    @(negedge clk);
    checkOutput("redir_r2_deq_valid", 32'(deqValid[0]), 32'd0);
    applyStimulus(1'b1, 1'b0, 32'd0, 1'b1);
    @(negedge clk);
    checkOutput("redir_r3_deq_valid",  32'(deqValid[0]), 32'd1);
    checkOutput("redir_r3_deq_instr",  deqInstr[0],      32'h100);
    checkOutput("redir_r3_deq_pcplus", deqPcplus[0],     32'h104);
    repeat (5) applyStimulus(1'b1, 1'b0, 32'd0, 1'b1);

    applyStimulus(1'b1, 1'b1, 32'h200, 1'b1);
    applyStimulus(1'b1, 1'b1, 32'h300, 1'b1);
    applyStimulus(1'b1, 1'b0, 32'd0, 1'b1);
    applyStimulus(1'b1, 1'b0, 32'd0, 1'b1);
    applyStimulus(1'b1, 1'b0, 32'd0, 1'b1);
    @(negedge clk);
    checkOutput("b2b_deq_instr", deqInstr[0], 32'h300);
    repeat (6) applyStimulus(1'b1, 1'b0, 32'd0, 1'b1);

    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      applyStimulus(1'b1, 1'b0, 32'd0, 1'b0);
      @(negedge clk);
      if (occ[0] == 4'd2) found = 1'b1;
    end
    checkOutput("reach_occ2", 32'(found), 32'd1);
    #1;
    rst = 1'b0;
    #1;
    checkOutput("async_rst_deq_valid", 32'(deqValid[0]), 32'd0);
    checkOutput("async_rst_occupancy", 32'(occ[0]),      32'd0);
    checkOutput("async_rst_imem_req",  32'(imemReq[0]),  32'd0);
    repeat (2) applyStimulus(1'b0, 1'b0, 32'd0, 1'b1);
    applyStimulus(1'b1, 1'b0, 32'd0, 1'b1);
    @(negedge clk);
    checkOutput("restart_imem_req",  32'(imemReq[0]), 32'd1);
    checkOutput("restart_imem_addr", imemAddr[0],     RESET_PC >> 2);

    for (int i = 0; i < 3000; i++) begin
      logic        rv;
      logic        rdy;
      logic [31:0] tgt;
      rv  = ($urandom_range(0, 99) == 0);
      rdy = ($urandom_range(0, 3) != 0);
      tgt = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF0 : ($urandom & 32'hFFFF_FFFC);
      applyStimulus(1'b1, rv, tgt, rdy);
    end
    repeat (10) applyStimulus(1'b1, 1'b0, 32'd0, 1'b1);

    @(negedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
